clock_display_ctrl: RTL and testbench

- Downstream consumer of the frequency divider's three slow square waves (1 Hz, 400 Hz, 5 Hz).
- Keeps an MM:SS time-of-day count and provides a two-button set mode.
- Drives a 4-digit multiplexed common-anode 7-segment display.
- Sits between the divider and the board pins. All logic runs on the system clock. The slow waves are treated as data and edge-detected, never used as clocks.

---
 rtl/clock_display_pkg.sv | 45 ++++
 rtl/clock_display_ctrl_seg7_decode.sv | 15 +
 rtl/clock_display_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_clock_display_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_display_pkg.sv
// clock_display_pkg
// Shared definitions for the MM:SS clock display controller:
//   - mode_e     : operating mode (RUN, SET_MIN, SET_SEC)
//   - BLANK_SEG  : active-low pattern with every segment off
//   - SEG_TABLE  : 16-entry active-low 7-segment table, index = BCD code,
//                  bit0 = segment a ... bit6 = segment g; codes 10-15 blank
//   - bcd60_inc  : increments a two-digit BCD value {tens, ones} modulo 60
package clock_display_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_MIN = 2'd1,
    MODE_SET_SEC = 2'd2
  } mode_e;

  localparam logic [6:0] BLANK_SEG = 7'h7F;

  // Entry [15] first, entry [0] last.
  localparam logic [15:0][6:0] SEG_TABLE = {
    BLANK_SEG, BLANK_SEG, BLANK_SEG, BLANK_SEG, BLANK_SEG, BLANK_SEG,
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

  // {tens, ones} + 1 with ones wrapping 9->0 and tens wrapping 5->0.
  function automatic logic [7:0] bcd60_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd5) r = 8'h00;
      else                r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/clock_display_ctrl_seg7_decode.sv
// seg7_decode
// Combinational BCD to active-low 7-segment decoder driven by SEG_TABLE.
// Ports:
//   bcd   in  4  BCD digit (10-15 decode to all segments off)
//   seg_n out 7  segments g..a, active low (bit0 = a)
module seg7_decode
  import clock_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_n
);

  assign seg_n = SEG_TABLE[bcd];

endmodule

// File: rtl/clock_display_ctrl.sv
// clock_display_ctrl
// MM:SS clock with a two-button set mode, driving a 4-digit multiplexed
// common-anode 7-segment display. The divider's slow square waves and the
// buttons are synchronised and edge-detected on clk; none is used as a clock.
//
// Parameter:
//   SYNC_STAGES  synchroniser depth on every slow input (must be >= 2)
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   clk_1Hz    in   rising edge = one second tick
//   clk_400Hz  in   rising edge = advance digit scan
//   clk_5Hz    in   blink phase level (only used with CLOCK_DISPLAY_BLINK_EN)
//   btn_mode   in   rising edge steps RUN -> SET_MIN -> SET_SEC -> RUN
//   btn_inc    in   rising edge increments the field selected by the mode
//   seg_n      out  7 segments g..a, active low
//   an_n       out  4 digit anodes, active low, an_n[0] = seconds ones
//   dp_n       out  decimal point, active low, lit on digit 2 (colon)
//   mode       out  0 = RUN, 1 = SET_MIN, 2 = SET_SEC
//
// Build option:
//   CLOCK_DISPLAY_BLINK_EN  when defined, the field being set blanks while
//                           the synchronised clk_5Hz is high.
module clock_display_ctrl
  import clock_display_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_1Hz,
  input  logic       clk_400Hz,
  input  logic       clk_5Hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [6:0] seg_n,
  output logic [3:0] an_n,
  output logic       dp_n,
  output logic [1:0] mode
);

  localparam int NUM_EDGE  = 4;
  localparam int IDX_1HZ   = 0;
  localparam int IDX_400HZ = 1;
  localparam int IDX_MODE  = 2;
  localparam int IDX_INC   = 3;

  logic [NUM_EDGE-1:0] raw_in;
  logic [NUM_EDGE-1:0] tick;

  assign raw_in = {btn_inc, btn_mode, clk_400Hz, clk_1Hz};

  // Synchroniser + history flop per edge-detected input. Everything resets
  // to 1 so an input held high across reset never yields a tick.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_EDGE; gi++) begin : g_edge
      logic [SYNC_STAGES-1:0] sync_reg;
      logic                   hist_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          sync_reg <= '1;
          hist_reg <= 1'b1;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw_in[gi]};
          hist_reg <= sync_reg[SYNC_STAGES-1];
        end
      end

      assign tick[gi] = sync_reg[SYNC_STAGES-1] & ~hist_reg;
    end
  endgenerate

`ifdef CLOCK_DISPLAY_BLINK_EN
  // The blink phase is a level, so only the synchroniser is needed.
  logic [SYNC_STAGES-1:0] blink_sync_reg;

  always_ff @(posedge clk) begin
    if (reset) blink_sync_reg <= '1;
    else       blink_sync_reg <= {blink_sync_reg[SYNC_STAGES-2:0], clk_5Hz};
  end
`else
  // Blink disabled: clk_5Hz feeds nothing and is trimmed by synthesis.
  logic unused_clk_5hz;
  assign unused_clk_5hz = clk_5Hz;
`endif

  // ---------------------------------------------------------------------
  // Time, mode and scan state
  // ---------------------------------------------------------------------
  logic [7:0] sec_reg, sec_next;   // {sec_t, sec_o}
  logic [7:0] min_reg, min_next;   // {min_t, min_o}
  mode_e      mode_reg, mode_next;
  logic [1:0] idx_reg, idx_next;

  always_comb begin
    sec_next  = sec_reg;
    min_next  = min_reg;
    mode_next = mode_reg;
    idx_next  = idx_reg + {1'b0, tick[IDX_400HZ]};

    // Time update uses the current mode, so a same-cycle mode tick takes
    // effect only after the tick/increment has been applied.
    case (mode_reg)
      MODE_RUN: begin
        if (tick[IDX_1HZ]) begin
          sec_next = bcd60_inc(sec_reg);
          if (sec_reg == 8'h59) min_next = bcd60_inc(min_reg);
        end
      end
      MODE_SET_MIN: if (tick[IDX_INC]) min_next = bcd60_inc(min_reg);
      MODE_SET_SEC: if (tick[IDX_INC]) sec_next = bcd60_inc(sec_reg);
      default: ;
    endcase

    if (tick[IDX_MODE]) begin
      case (mode_reg)
        MODE_RUN:     mode_next = MODE_SET_MIN;
        MODE_SET_MIN: mode_next = MODE_SET_SEC;
        default:      mode_next = MODE_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sec_reg  <= 8'h00;
      min_reg  <= 8'h00;
      mode_reg <= MODE_RUN;
      idx_reg  <= 2'd0;
    end else begin
      sec_reg  <= sec_next;
      min_reg  <= min_next;
      mode_reg <= mode_next;
      idx_reg  <= idx_next;
    end
  end

  assign mode = mode_reg;

  // ---------------------------------------------------------------------
  // Display path (registered outputs)
  // ---------------------------------------------------------------------
  logic [3:0] digit;
  logic [6:0] dec_seg;
  logic       blank;
  logic [6:0] seg_next;
  logic [3:0] an_next;
  logic       dp_next;

  always_comb begin
    case (idx_reg)
      2'd0:    digit = sec_reg[3:0];
      2'd1:    digit = sec_reg[7:4];
      2'd2:    digit = min_reg[3:0];
      default: digit = min_reg[7:4];
    endcase
  end

  seg7_decode u_seg7_decode (
    .bcd   (digit),
    .seg_n (dec_seg)
  );

`ifdef CLOCK_DISPLAY_BLINK_EN
  // idx_reg[1] is set for the minute digits (2, 3).
  assign blank = blink_sync_reg[SYNC_STAGES-1] &
                 (((mode_reg == MODE_SET_MIN) &  idx_reg[1]) |
                  ((mode_reg == MODE_SET_SEC) & ~idx_reg[1]));
`else
  assign blank = 1'b0;
`endif

  assign seg_next = blank ? BLANK_SEG : dec_seg;
  assign an_next  = ~(4'b0001 << idx_reg);
  assign dp_next  = (idx_reg != 2'd2);

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_n <= SEG_TABLE[0];
      an_n  <= 4'b1110;
      dp_n  <= 1'b1;
    end else begin
      seg_n <= seg_next;
      an_n  <= an_next;
      dp_n  <= dp_next;
    end
  end

endmodule

// File: tb/tb_clock_display_ctrl.sv
// tb_clock_display_ctrl
// Self-checking bench for clock_display_ctrl. A behavioural model keeps the
// time as plain integer minutes/seconds, the mode as 0..2 and the scan
// position as 0..3; every button/wave pulse updates both DUT and model.
module tb_clock_display_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clk_1Hz = 1'b0;
  logic       clk_400Hz = 1'b0;
  logic       clk_5Hz = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [6:0] seg_n;
  logic [3:0] an_n;
  logic       dp_n;
  logic [1:0] mode;

  clock_display_ctrl #(.SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .clk_1Hz   (clk_1Hz),
    .clk_400Hz (clk_400Hz),
    .clk_5Hz   (clk_5Hz),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .seg_n     (seg_n),
    .an_n      (an_n),
    .dp_n      (dp_n),
    .mode      (mode)
  );

  always #5 clk = ~clk;

  // Reference model state
  int m_sec, m_min, m_mode, m_idx;
  int pass_cnt  = 0;
  int total_cnt = 0;

  function automatic logic [6:0] digit_seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected segments for display position pos given the model state.
  function automatic logic [6:0] exp_seg_at(input int pos);
    int d;
    logic [6:0] s;
    case (pos)
      0: d = m_sec % 10;
      1: d = m_sec / 10;
      2: d = m_min % 10;
      default: d = m_min / 10;
    endcase
    s = digit_seg(d);
`ifdef CLOCK_DISPLAY_BLINK_EN
    if (clk_5Hz && ((m_mode == 1 && pos >= 2) || (m_mode == 2 && pos < 2)))
      s = 7'b1111111;
`endif
    return s;
  endfunction

  // One clean pulse on the selected inputs (6 cycles high, 6 low) plus the
  // matching model update. Same-pulse events: time effect first, then mode.
  task automatic do_pulse(input bit p1, input bit p400, input bit pm, input bit pi);
    @(negedge clk);
    clk_1Hz = p1; clk_400Hz = p400; btn_mode = pm; btn_inc = pi;
    repeat (6) @(negedge clk);
    clk_1Hz = 1'b0; clk_400Hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    repeat (6) @(negedge clk);
    if (p1 && m_mode == 0) begin
      m_sec = m_sec + 1;
      if (m_sec == 60) begin
        m_sec = 0;
        m_min = (m_min + 1) % 60;
      end
    end
    if (pi && m_mode == 1) m_min = (m_min + 1) % 60;
    if (pi && m_mode == 2) m_sec = (m_sec + 1) % 60;
    if (p400) m_idx = (m_idx + 1) % 4;
    if (pm) m_mode = (m_mode + 1) % 3;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clk_1Hz = 1'b0; clk_400Hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; clk_5Hz = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    m_sec = 0; m_min = 0; m_mode = 0; m_idx = 0;
    repeat (4) @(negedge clk);
  endtask

  // Scan all four digits (four 400 Hz pulses) and collect segments by the
  // anode that was low; a slot never seen keeps the 7'h55 sentinel.
  task automatic read_digits(output logic [3:0][6:0] d);
    d = {4{7'h55}};
    for (int k = 0; k < 4; k++) begin
      case (an_n)
        4'b1110: d[0] = seg_n;
        4'b1101: d[1] = seg_n;
        4'b1011: d[2] = seg_n;
        4'b0111: d[3] = seg_n;
        default: ;
      endcase
      do_pulse(1'b0, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic set_time(input int mm, input int ss);
    do_pulse(0, 0, 1, 0);
    while (m_min != mm) do_pulse(0, 0, 0, 1);
    do_pulse(0, 0, 1, 0);
    while (m_sec != ss) do_pulse(0, 0, 0, 1);
    do_pulse(0, 0, 1, 0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    clk_1Hz = 1'b1; clk_400Hz = 1'b1; btn_mode = 1'b1; btn_inc = 1'b1; clk_5Hz = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    m_sec = 0; m_min = 0; m_mode = 0; m_idx = 0;
    repeat (10) @(negedge clk);
    total_cnt++;
    if (an_n !== 4'b1110) $display("FAIL reset_an_n got=%b exp=1110", an_n);
    else pass_cnt++;
    total_cnt++;
    if (seg_n !== 7'b1000000) $display("FAIL reset_seg_n got=%b exp=1000000", seg_n);
    else pass_cnt++;
    total_cnt++;
    if (dp_n !== 1'b1) $display("FAIL reset_dp_n got=%b exp=1", dp_n);
    else pass_cnt++;
    total_cnt++;
    if (mode !== 2'd0) $display("FAIL reset_mode got=%0d exp=0", mode);
    else pass_cnt++;
    clk_1Hz = 1'b0; clk_400Hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; clk_5Hz = 1'b0;
    repeat (6) @(negedge clk);
    $display("test_reset: done");
  endtask

  task automatic test_rollover();
    logic [3:0][6:0] d;
    do_reset();
    repeat (59) do_pulse(1, 0, 0, 0);
    read_digits(d);
    for (int p = 0; p < 4; p++) begin
      total_cnt++;
      if (d[p] !== exp_seg_at(p)) $display("FAIL rollover_0059 pos=%0d got=%b exp=%b", p, d[p], exp_seg_at(p));
      else pass_cnt++;
    end
    do_pulse(1, 0, 0, 0);
    read_digits(d);
    for (int p = 0; p < 4; p++) begin
      total_cnt++;
      if (d[p] !== exp_seg_at(p)) $display("FAIL rollover_0100 pos=%0d got=%b exp=%b", p, d[p], exp_seg_at(p));
      else pass_cnt++;
    end
    set_time(59, 59);
    do_pulse(1, 0, 0, 0);
    read_digits(d);
    for (int p = 0; p < 4; p++) begin
      total_cnt++;
      if (d[p] !== exp_seg_at(p)) $display("FAIL rollover_5959 pos=%0d got=%b exp=%b", p, d[p], exp_seg_at(p));
      else pass_cnt++;
    end
    $display("test_rollover: time now %02d:%02d", m_min, m_sec);
  endtask

  task automatic test_setting();
    logic [3:0][6:0] d;
    do_reset();
    do_pulse(0, 0, 1, 0);
    total_cnt++;
    if (mode !== 2'd1) $display("FAIL set_mode1 got=%0d exp=1", mode);
    else pass_cnt++;
    repeat (3) do_pulse(0, 0, 0, 1);
    read_digits(d);
    for (int p = 0; p < 4; p++) begin
      total_cnt++;
      if (d[p] !== exp_seg_at(p)) $display("FAIL set_min3 pos=%0d got=%b exp=%b", p, d[p], exp_seg_at(p));
      else pass_cnt++;
    end
    do_pulse(0, 0, 1, 0);
    total_cnt++;
    if (mode !== 2'd2) $display("FAIL set_mode2 got=%0d exp=2", mode);
    else pass_cnt++;
    repeat (4) do_pulse(1, 0, 0, 0);
    repeat (60) do_pulse(0, 0, 0, 1);
    read_digits(d);
    for (int p = 0; p < 4; p++) begin
      total_cnt++;
      if (d[p] !== exp_seg_at(p)) $display("FAIL set_sec_wrap pos=%0d got=%b exp=%b", p, d[p], exp_seg_at(p));
      else pass_cnt++;
    end
    do_pulse(0, 0, 1, 0);
    total_cnt++;
    if (mode !== 2'd0) $display("FAIL set_mode0 got=%0d exp=0", mode);
    else pass_cnt++;
    $display("test_setting: time now %02d:%02d mode %0d", m_min, m_sec, m_mode);
  endtask

  task automatic test_scan();
    do_reset();
    set_time(12, 34);
    for (int k = 0; k < 5; k++) begin
      do_pulse(0, 1, 0, 0);
      total_cnt++;
      if (an_n !== ~(4'b0001 << m_idx)) $display("FAIL scan_an step=%0d got=%b exp=%b", k, an_n, ~(4'b0001 << m_idx));
      else pass_cnt++;
      total_cnt++;
      if (seg_n !== exp_seg_at(m_idx)) $display("FAIL scan_seg step=%0d got=%b exp=%b", k, seg_n, exp_seg_at(m_idx));
      else pass_cnt++;
      total_cnt++;
      if (dp_n !== (m_idx != 2)) $display("FAIL scan_dp step=%0d got=%b exp=%b", k, dp_n, (m_idx != 2));
      else pass_cnt++;
      $display("test_scan: step %0d an_n=%b seg_n=%b dp_n=%b", k, an_n, seg_n, dp_n);
    end
  endtask

  task automatic test_same_cycle();
    logic [3:0][6:0] d;
    do_reset();
    repeat (9) do_pulse(1, 0, 0, 0);
    do_pulse(1, 0, 1, 0);
    total_cnt++;
    if (mode !== 2'd1) $display("FAIL same_tick_mode got=%0d exp=1", mode);
    else pass_cnt++;
    read_digits(d);
    for (int p = 0; p < 4; p++) begin
      total_cnt++;
      if (d[p] !== exp_seg_at(p)) $display("FAIL same_tick_time pos=%0d got=%b exp=%b", p, d[p], exp_seg_at(p));
      else pass_cnt++;
    end
    do_pulse(0, 0, 1, 1);
    total_cnt++;
    if (mode !== 2'd2) $display("FAIL same_inc_mode got=%0d exp=2", mode);
    else pass_cnt++;
    read_digits(d);
    for (int p = 0; p < 4; p++) begin
      total_cnt++;
      if (d[p] !== exp_seg_at(p)) $display("FAIL same_inc_time pos=%0d got=%b exp=%b", p, d[p], exp_seg_at(p));
      else pass_cnt++;
    end
    $display("test_same_cycle: time now %02d:%02d mode %0d", m_min, m_sec, m_mode);
  endtask

  task automatic test_blink();
    logic [3:0][6:0] d;
    do_reset();
    do_pulse(0, 0, 1, 0);
    for (int ph = 1; ph >= 0; ph--) begin
      clk_5Hz = ph[0];
      repeat (6) @(negedge clk);
      read_digits(d);
      for (int p = 0; p < 4; p++) begin
        total_cnt++;
        if (d[p] !== exp_seg_at(p)) $display("FAIL blink_min ph=%0d pos=%0d got=%b exp=%b", ph, p, d[p], exp_seg_at(p));
        else pass_cnt++;
      end
    end
    do_pulse(0, 0, 1, 0);
    clk_5Hz = 1'b1;
    repeat (6) @(negedge clk);
    read_digits(d);
    for (int p = 0; p < 4; p++) begin
      total_cnt++;
      if (d[p] !== exp_seg_at(p)) $display("FAIL blink_sec pos=%0d got=%b exp=%b", p, d[p], exp_seg_at(p));
      else pass_cnt++;
    end
    clk_5Hz = 1'b0;
    repeat (6) @(negedge clk);
    $display("test_blink: done");
  endtask

  task automatic test_random();
    int op;
    for (int n = 0; n < 200; n++) begin
      clk_5Hz = 1'($urandom_range(0, 1));
      op = int'($urandom_range(0, 9));
      case (op)
        0, 1, 2: do_pulse(1, 0, 0, 0);
        3, 4:    do_pulse(0, 1, 0, 0);
        5:       do_pulse(0, 0, 1, 0);
        6, 7:    do_pulse(0, 0, 0, 1);
        8:       do_pulse(1, 0, 1, 0);
        default: do_pulse(0, 0, 1, 1);
      endcase
      total_cnt++;
      if (mode !== 2'(m_mode)) $display("FAIL rand_mode n=%0d op=%0d got=%0d exp=%0d", n, op, mode, m_mode);
      else pass_cnt++;
      total_cnt++;
      if (an_n !== ~(4'b0001 << m_idx)) $display("FAIL rand_an n=%0d got=%b exp=%b", n, an_n, ~(4'b0001 << m_idx));
      else pass_cnt++;
      total_cnt++;
      if (seg_n !== exp_seg_at(m_idx)) $display("FAIL rand_seg n=%0d op=%0d got=%b exp=%b", n, op, seg_n, exp_seg_at(m_idx));
      else pass_cnt++;
      total_cnt++;
      if (dp_n !== (m_idx != 2)) $display("FAIL rand_dp n=%0d got=%b exp=%b", n, dp_n, (m_idx != 2));
      else pass_cnt++;
    end
    clk_5Hz = 1'b0;
    $display("test_random: final %02d:%02d mode %0d idx %0d", m_min, m_sec, m_mode, m_idx);
  endtask

  initial begin
    test_reset();
    test_rollover();
    test_setting();
    test_scan();
    test_same_cycle();
    test_blink();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog time limit reached passed=%0d total=%0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

endmodule
